// File: rtl/olimp_pkg.sv
// Shared types and constants for the olimp dot-product sequencer.
package olimp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } olimp_state_e;

  localparam int OLIMP_DATA_W  = 64;
  localparam int OLIMP_COEF_W  = 128;
  localparam int OLIMP_ACC_W   = 32;
  localparam int OLIMP_MAC_LAT = 3;

endpackage

// File: rtl/olimp_acc_lane.sv
// One 32-bit signed lane accumulator with clear and enable.
// OLIMP_ACC_SAT_EN selects a clamping add plus a sticky saturation flag.
module olimp_acc_lane
  import olimp_pkg::*;
(
  input  logic                   clk_dsp,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic [OLIMP_ACC_W-1:0] i_add,
`ifdef OLIMP_ACC_SAT_EN
  output logic                   o_sat,
`endif
  output logic [OLIMP_ACC_W-1:0] o_acc
);

  logic [OLIMP_ACC_W-1:0] r_acc;
  logic [OLIMP_ACC_W-1:0] w_next;

`ifdef OLIMP_ACC_SAT_EN
  logic [OLIMP_ACC_W:0] w_sum;
  logic                 w_ovf;
  logic                 r_sat;

  // A 33-bit sum whose top two bits disagree has left the 32-bit signed range.
  always_comb begin
    w_sum  = {r_acc[OLIMP_ACC_W-1], r_acc} + {i_add[OLIMP_ACC_W-1], i_add};
    w_ovf  = w_sum[OLIMP_ACC_W] ^ w_sum[OLIMP_ACC_W-1];
    w_next = w_sum[OLIMP_ACC_W-1:0];
    if (w_ovf) begin
      w_next = w_sum[OLIMP_ACC_W] ? {1'b1, {(OLIMP_ACC_W-1){1'b0}}}
                                  : {1'b0, {(OLIMP_ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_sat <= 1'b0;
    end else if (i_en && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign o_sat = r_sat;
`else
  assign w_next = r_acc + i_add;
`endif

  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/olimp_dot_seq.sv
// Runs one multi-beat dot-product command on the vector MAC unit and returns two lane sums.
// OLIMP_ACC_SAT_EN enables saturating accumulation and the res_sat output.
module olimp_dot_seq
  import olimp_pkg::*;
#(
  parameter int MAC_LAT = OLIMP_MAC_LAT,
  parameter int LEN_W   = 16
) (
  input  logic                    clk_dsp,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OLIMP_DATA_W-1:0] in_data,
  input  logic [OLIMP_COEF_W-1:0] in_coef,
  output logic [OLIMP_DATA_W-1:0] vec_data,
  output logic [OLIMP_COEF_W-1:0] vec_coef,
  input  logic [OLIMP_ACC_W-1:0]  vec_acc0,
  input  logic [OLIMP_ACC_W-1:0]  vec_acc1,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OLIMP_ACC_W-1:0]  res_acc0,
  output logic [OLIMP_ACC_W-1:0]  res_acc1,
`ifdef OLIMP_ACC_SAT_EN
  output logic                    res_sat,
`endif
  output logic                    busy,
  output logic [1:0]              o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // ready depends only on state, never on the matching valid.
  olimp_state_e              r_state;
  olimp_state_e              w_state_nxt;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_issued;
  logic [LEN_W-1:0]          r_retired;
  logic [LEN_W-1:0]          w_len_m1;
  logic [MAC_LAT:0]          r_tag;
  logic [OLIMP_DATA_W-1:0]   r_vec_data;
  logic [OLIMP_COEF_W-1:0]   r_vec_coef;
  logic                      w_cmd_fire;
  logic                      w_in_fire;
  logic                      w_res_fire;
  logic                      w_tag_exit;

  assign cmd_ready   = (r_state == IDLE);
  assign in_ready    = (r_state == RUN);
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;
  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_in_fire   = in_valid & in_ready;
  assign w_res_fire  = res_valid & res_ready;
  assign w_len_m1    = r_len - LEN_W'(1);
  // A tag reaching the top bit lines up with that beat's sums on vec_acc0/vec_acc1.
  assign w_tag_exit  = r_tag[MAC_LAT];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_state_nxt = (cmd_len == '0) ? DONE : RUN;
      RUN:     if (w_in_fire && (r_issued == w_len_m1)) w_state_nxt = DRAIN;
      DRAIN:   if (w_tag_exit && (r_retired == w_len_m1)) w_state_nxt = DONE;
      DONE:    if (w_res_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Idle cycles feed zeros so the unit's products for those cycles are zero.
  always_ff @(posedge clk_dsp or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_retired  <= '0;
      r_tag      <= '0;
      r_vec_data <= '0;
      r_vec_coef <= '0;
    end else begin
      r_tag      <= {r_tag[MAC_LAT-1:0], w_in_fire};
      r_vec_data <= w_in_fire ? in_data : '0;
      r_vec_coef <= w_in_fire ? in_coef : '0;
      if (w_cmd_fire) begin
        r_len     <= cmd_len;
        r_issued  <= '0;
        r_retired <= '0;
      end else begin
        if (w_in_fire)  r_issued  <= r_issued + LEN_W'(1);
        if (w_tag_exit) r_retired <= r_retired + LEN_W'(1);
      end
    end
  end

  assign vec_data = r_vec_data;
  assign vec_coef = r_vec_coef;

`ifdef OLIMP_ACC_SAT_EN
  logic w_sat0;
  logic w_sat1;
  assign res_sat = w_sat0 | w_sat1;
`endif

  olimp_acc_lane u_lane0 (
    .clk_dsp (clk_dsp),
    .rst_n   (rst_n),
    .i_clr   (w_cmd_fire),
    .i_en    (w_tag_exit),
    .i_add   (vec_acc0),
`ifdef OLIMP_ACC_SAT_EN
    .o_sat   (w_sat0),
`endif
    .o_acc   (res_acc0)
  );

  olimp_acc_lane u_lane1 (
    .clk_dsp (clk_dsp),
    .rst_n   (rst_n),
    .i_clr   (w_cmd_fire),
    .i_en    (w_tag_exit),
    .i_add   (vec_acc1),
`ifdef OLIMP_ACC_SAT_EN
    .o_sat   (w_sat1),
`endif
    .o_acc   (res_acc1)
  );

endmodule

// File: tb/tb_olimp_dot_seq.sv
// Directed bench for olimp_dot_seq with a behavioural 3-cycle vector MAC unit model.
// Builds with or without OLIMP_ACC_SAT_EN.
module tb_olimp_dot_seq;
  import olimp_pkg::*;

  localparam int LEN_W = 16;

  // ---------------- clock / reset ----------------
  logic clk_dsp = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_dsp = ~clk_dsp;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [63:0]      in_data   = '0;
  logic [127:0]     in_coef   = '0;
  logic [63:0]      vec_data;
  logic [127:0]     vec_coef;
  logic [31:0]      vec_acc0;
  logic [31:0]      vec_acc1;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_acc0;
  logic [31:0]      res_acc1;
  logic             busy;
  logic [1:0]       o_dbg_state;
`ifdef OLIMP_ACC_SAT_EN
  logic             res_sat;
`endif

  olimp_dot_seq #(.MAC_LAT(3), .LEN_W(LEN_W)) dut (
    .clk_dsp     (clk_dsp),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_coef     (in_coef),
    .vec_data    (vec_data),
    .vec_coef    (vec_coef),
    .vec_acc0    (vec_acc0),
    .vec_acc1    (vec_acc1),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_acc0    (res_acc0),
    .res_acc1    (res_acc1),
`ifdef OLIMP_ACC_SAT_EN
    .res_sat     (res_sat),
`endif
    .busy        (busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- vector unit model: 8 x u8 data, 2 lanes of 8 x s8 coef ----------------
  function automatic logic [31:0] lane_sum(input logic [63:0] d, input logic [127:0] c, input int k);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      s += int'(d[i*8 +: 8]) * int'($signed(c[(k*8+i)*8 +: 8]));
    end
    return s;
  endfunction

  logic [31:0] m_a0 [3] = '{default: '0};
  logic [31:0] m_a1 [3] = '{default: '0};
  always @(posedge clk_dsp) begin
    m_a0[0] <= lane_sum(vec_data, vec_coef, 0);
    m_a1[0] <= lane_sum(vec_data, vec_coef, 1);
    m_a0[1] <= m_a0[0];
    m_a1[1] <= m_a1[0];
    m_a0[2] <= m_a0[1];
    m_a1[2] <= m_a1[1];
  end
  assign vec_acc0 = m_a0[2];
  assign vec_acc1 = m_a1[2];

  // ---------------- scoreboard ----------------
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_dsp);
    #1;
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_len   = LEN_W'($urandom_range(0, 65535));
  endtask

  task automatic send_beat(input logic [7:0] dv, input logic [7:0] cv);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = {8{dv}};
    in_coef  = {16{cv}};
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom()};
    in_coef  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom()};
    step();
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic take_res(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk({tag, "_acc0"}, res_acc0, e);
    chk({tag, "_acc1"}, res_acc1, e);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, res_valid, cmd_ready}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int unstable;
    int gaps;

    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outs", {27'd0, busy, res_valid, in_ready, o_dbg_state}, 32'd0);
    chk("rst_res", res_acc0 | res_acc1 | vec_data[31:0], 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // single beat: 8 x 1*1 per lane, result MAC_LAT+1 edges after the fire
    exp_q.push_back(32'd8);
    send_cmd(16'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_beat(8'h01, 8'h01);
    wait_res(lat);
    chk("t1_latency", 32'(lat), 32'd4);
    take_res("t1");

    // signed back-to-back: 4 x 8 x 2*(-3) = -192
    exp_q.push_back(32'hFFFF_FF40);
    send_cmd(16'd4);
    in_valid = 1'b1;
    in_data  = {8{8'h02}};
    in_coef  = {16{8'hFD}};
    for (int i = 0; i < 4; i++) begin
      chk("t2_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    chk("t2_drain_ready", 32'(in_ready), 32'd0);
    wait_res(lat);
    take_res("t2");

    // bubbles 1,0,0,1,0,1 with beats 1/2/3 -> 8+16+24 = 48
    exp_q.push_back(32'd48);
    send_cmd(16'd3);
    send_beat(8'h01, 8'h01);
    bubble();
    chk("t3_bubble_zero", vec_data[31:0] | vec_data[63:32], 32'd0);
    bubble();
    send_beat(8'h02, 8'h01);
    bubble();
    send_beat(8'h03, 8'h01);
    chk("t3_drain_state", 32'(o_dbg_state), 32'(DRAIN));
    chk("t3_drain_ready", 32'(in_ready), 32'd0);
    wait_res(lat);

    // hold off the result for 10 cycles
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (res_acc0 !== 32'd48 || res_acc1 !== 32'd48 || !res_valid || cmd_ready) unstable++;
    end
    chk("t3_hold_stable", 32'(unstable), 32'd0);
    chk("t3_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    take_res("t3");

    // zero length: DONE right after the command edge with a zero result
    exp_q.push_back(32'd0);
    send_cmd(16'd0);
    chk("t4_res_valid", 32'(res_valid), 32'd1);
    take_res("t4");

    // overflow: 20000 x 129032 per lane
`ifdef OLIMP_ACC_SAT_EN
    exp_q.push_back(32'h7FFF_FFFF);
`else
    exp_q.push_back(32'h99D1_7100);
`endif
    send_cmd(16'd20000);
    in_valid = 1'b1;
    in_data  = {8{8'h7F}};
    in_coef  = {16{8'h7F}};
    gaps = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!in_ready) gaps++;
      step();
    end
    in_valid = 1'b0;
    chk("t5_no_gaps", 32'(gaps), 32'd0);
    wait_res(lat);
`ifdef OLIMP_ACC_SAT_EN
    chk("t5_res_sat", 32'(res_sat), 32'd1);
`endif
    take_res("t5");

    // reset after 2 of 5 beats, then a clean single beat
    send_cmd(16'd5);
    send_beat(8'h05, 8'h01);
    send_beat(8'h05, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_rst_outs", {27'd0, busy, res_valid, in_ready, o_dbg_state}, 32'd0);
    chk("t6_rst_res", res_acc0 | res_acc1 | vec_data[31:0] | vec_data[63:32], 32'd0);
    step();
    rst_n = 1'b1;
    exp_q.push_back(32'd8);
    send_cmd(16'd1);
    send_beat(8'h01, 8'h01);
    wait_res(lat);
    chk("t6_latency", 32'(lat), 32'd4);
    take_res("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/olimp_dot_seq.md
Name: olimp_dot_seq

Overview:
- Sequencer that runs one multi-beat dot-product command on the VEC-8U8-16I8-2S32 vector MAC unit.
- Accepts a command (beat count), streams data/coef beats into the unit with valid/ready, and tracks beats through the unit's fixed pipeline (clk_en tied high, so no stall).
- Accumulates the unit's two per-beat lane sums into 32-bit accumulators and returns them through a result handshake.
- Sits between the host/DMA beat stream and the vector unit.

Parameters:
- MAC_LAT, 3: cycles from vec_data/vec_coef to matching vec_acc0/vec_acc1.
- LEN_W, 16: width of the beat count.

Ports:
- clk_dsp  in  1  DSP clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  number of beats; 0 is legal.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_data  in  64  8 x 8-bit data.
- in_coef  in  128  16 x int8 coefficients.
- vec_data  out  64  registered data to the vector unit.
- vec_coef  out  128  registered coef to the vector unit.
- vec_acc0  in  32  lane-0 sum from the vector unit.
- vec_acc1  in  32  lane-1 sum from the vector unit.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_acc0  out  32  lane-0 accumulated sum, signed.
- res_acc1  out  32  lane-1 accumulated sum, signed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State=IDLE; accumulators, counters and tag pipe cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd fire latches len, clears acc0/acc1, issued, retired.
  - len != 0 -> RUN.
  - len == 0 -> DONE with zero result.
- RUN:
  - in_ready=1.
  - On each beat fire: vec_data/vec_coef <= in_data/in_coef; issued++.
  - No fire: vec_data/vec_coef <= 0, which makes the products zero.
  - Fire with issued == len-1 -> DRAIN; in_ready drops on the same edge.
- Tag pipe:
  - 1-bit shift register of depth MAC_LAT+1. Bit 0 is set on beat fire.
  - The tag exits aligned with the valid vec_acc0/vec_acc1 of that beat, i.e. MAC_LAT cycles after vec_data updates.
  - On tag exit: acc0 += vec_acc0, acc1 += vec_acc1 (32-bit signed); retired++.
- DRAIN:
  - in_ready=0.
  - The edge that retires beat len moves to DONE; that accumulate is included in the result.
- Latency: the last beat's fire edge E gives res_valid high after edge E+MAC_LAT+1.
- Throughput: one beat per cycle, no bubbles inserted by this block.
- DONE:
  - res_valid=1; res_acc0/res_acc1 driven from the accumulators and held stable while res_ready=0.
  - Fire -> IDLE.
  - A command in the cycle after the fire is accepted normally. There is no IDLE bypass: cmd_ready is 0 while in DONE.
- in_valid gaps in RUN are bubbles. Final sums are independent of bubble pattern.
- Unit-output stall is impossible: backpressure exists only at in_ready and cmd_ready. A beat in flight always completes.
- Wrap: without the optional feature, accumulation wraps modulo 2^32.
- rst_n low mid-operation: immediate return to the reset values. In-flight tags are discarded; any vec_acc values returning later are ignored.
- cmd_len and in_* are ignored outside their accepting states.

Optional Feature:
- Macro: OLIMP_ACC_SAT_EN.
- Defined: each accumulate is a 33-bit signed add, clamped to 0x7FFFFFFF / 0x80000000.
- Defined: a sticky res_sat output (1 bit) is added; set on any clamp, cleared on cmd fire.
- Undefined: plain 32-bit wrap add, and no res_sat port.

Decomposition:
- Package olimp_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - constants OLIMP_DATA_W=64, OLIMP_COEF_W=128, OLIMP_ACC_W=32, OLIMP_MAC_LAT=3.
- One sub-module, olimp_acc_lane:
  - a single 32-bit accumulator with clear, enable and the optional saturation;
  - instantiated twice.

Test Plan:
- Single beat: len=1, data bytes all 0x01, coef bytes all 0x01 -> res_acc0=8, res_acc1=8; res_valid rises MAC_LAT+1 edges after the beat fire.
- Signed, back-to-back: len=4, data bytes 0x02, coef bytes 0xFD (-3), in_valid constant -> each 0xFFFFFF40 (-192); no in_ready gaps.
- Bubbles: len=3, in_valid pattern 1,0,0,1,0,1 with beat values 1/2/3 in all bytes (coef=1) -> each lane 8+16+24=48; DRAIN entered after third fire.
- Backpressure and zero length:
  - res_ready held low 10 cycles -> res_* stable, cmd_ready=0.
  - Next cmd with len=0 -> res_valid next cycle, results 0.
- Overflow: len=20000, data=0x7F, coef=0x7F (129032 per beat) -> 0x99D17100 without OLIMP_ACC_SAT_EN; 0x7FFFFFFF with res_sat=1 when it is defined.
- Reset mid-RUN: rst_n pulsed low after 2 of 5 beats -> all outputs at reset values, IDLE; a following len=1 command yields a clean result with no residue.
